// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register latency countdown at decode/issue; raises stall on RAW/WAW hazards.
// Optional macro HAZARD_SCOREBOARD_STATS_EN adds a saturating stall_cycles counter output.
module hazard_scoreboard #(
   parameter int NREGS     = 32,
   parameter int ADDR_W    = 5,
   parameter int LAT_W     = 3,
   parameter int FLUSH_MIN = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_rs1,
   input  logic [ADDR_W-1:0] issue_rs2,
   input  logic [ADDR_W-1:0] issue_rd,
   input  logic              issue_wr,
   input  logic [LAT_W-1:0]  issue_lat,
   input  logic              freeze,
   input  logic              flush,
   output logic              stall,
   output logic              accept,
   output logic [NREGS-1:0]  busy
`ifdef HAZARD_SCOREBOARD_STATS_EN
   ,
   output logic [31:0]       stall_cycles
`endif
);

   logic [LAT_W-1:0] cnt_q [NREGS];
   logic [LAT_W-1:0] cnt_d [NREGS];
   logic             raw;
   logic             waw;

   always_comb begin
      raw = ((issue_rs1 != '0) && (cnt_q[issue_rs1] != '0)) ||
            ((issue_rs2 != '0) && (cnt_q[issue_rs2] != '0));
      // A younger write may not retire before an older write to the same register.
      waw = issue_wr && (issue_rd != '0) && (cnt_q[issue_rd] > issue_lat);
   end

   assign stall  = reset_n && issue_valid && (raw || waw);
   assign accept = reset_n && issue_valid && !stall && !freeze && !flush;

   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         cnt_d[r] = cnt_q[r];
         if (r == 0) begin
            cnt_d[r] = '0;
         end else if (!freeze) begin
            // Large counts on flush belong to squashed younger ops; small ones are older and still retire.
            if (flush && (int'(cnt_q[r]) >= FLUSH_MIN)) begin
               cnt_d[r] = '0;
            end else if (cnt_q[r] != '0) begin
               cnt_d[r] = cnt_q[r] - LAT_W'(1);
            end
            if (accept && issue_wr && (int'(issue_rd) == r)) begin
               cnt_d[r] = issue_lat;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < NREGS; r++) begin
            cnt_q[r] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      busy = '0;
      for (int r = 1; r < NREGS; r++) begin
         busy[r] = (cnt_q[r] != '0);
      end
   end

`ifdef HAZARD_SCOREBOARD_STATS_EN
   logic [31:0] stall_cycles_q;
   logic [31:0] stall_cycles_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall && !freeze && (stall_cycles_q != 32'hFFFF_FFFF)) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cycles_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic vs an integer-array model.
module tb_hazard_scoreboard;
   localparam int NREGS = 32;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        issue_valid;
   logic [4:0]  issue_rs1;
   logic [4:0]  issue_rs2;
   logic [4:0]  issue_rd;
   logic        issue_wr;
   logic [2:0]  issue_lat;
   logic        freeze;
   logic        flush;
   logic        stall;
   logic        accept;
   logic [31:0] busy;
`ifdef HAZARD_SCOREBOARD_STATS_EN
   logic [31:0] stall_cycles;
   longint      exp_stats = 0;
`endif

   int          m [NREGS];
   int          n_checks = 0;
   int          n_pass = 0;
   logic        last_stall;
   logic        last_accept;
   logic [31:0] last_busy;

   always #5 clk = ~clk;

   hazard_scoreboard dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .issue_valid (issue_valid),
      .issue_rs1   (issue_rs1),
      .issue_rs2   (issue_rs2),
      .issue_rd    (issue_rd),
      .issue_wr    (issue_wr),
      .issue_lat   (issue_lat),
      .freeze      (freeze),
      .flush       (flush),
      .stall       (stall),
      .accept      (accept),
      .busy        (busy)
`ifdef HAZARD_SCOREBOARD_STATS_EN
      ,
      .stall_cycles(stall_cycles)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expd);
      n_checks++;
      if (got === expd) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expd);
   endtask

   function automatic logic [31:0] model_busy();
      logic [31:0] b;
      b = '0;
      for (int r = 1; r < NREGS; r++) b[r] = (m[r] != 0);
      return b;
   endfunction

   // One issue cycle: drive at negedge, check combinational outputs, then advance the model at posedge.
   task automatic step(input logic v, input int rs1, input int rs2, input int rd,
                       input logic wr, input int lat, input logic frz, input logic fl);
      logic es;
      logic ea;
      @(negedge clk);
      issue_valid = v;
      issue_rs1   = 5'(rs1);
      issue_rs2   = 5'(rs2);
      issue_rd    = 5'(rd);
      issue_wr    = wr;
      issue_lat   = 3'(lat);
      freeze      = frz;
      flush       = fl;
      #1;
      es = v && ((rs1 != 0 && m[rs1] != 0) || (rs2 != 0 && m[rs2] != 0) ||
                 (wr && rd != 0 && m[rd] > lat));
      ea = v && !es && !frz && !fl;
      check("busy", busy, model_busy());
      check("stall", stall, es);
      check("accept", accept, ea);
`ifdef HAZARD_SCOREBOARD_STATS_EN
      check("stall_cycles", stall_cycles, exp_stats);
`endif
      last_stall  = stall;
      last_accept = accept;
      last_busy   = busy;
      @(posedge clk);
      if (!frz) begin
`ifdef HAZARD_SCOREBOARD_STATS_EN
         if (es && exp_stats < 64'hFFFF_FFFF) exp_stats++;
`endif
         for (int r = 1; r < NREGS; r++) begin
            if (fl && m[r] >= 2) m[r] = 0;
            else if (m[r] > 0) m[r] = m[r] - 1;
         end
         if (ea && wr && rd != 0) m[rd] = lat;
      end
   endtask

   task automatic reset_and_check(input int reg_busy);
      @(negedge clk);
      reset_n     = 1'b0;
      issue_valid = 1'b1;
      issue_rs1   = 5'(reg_busy);
      issue_rs2   = 5'(reg_busy);
      issue_rd    = 5'(reg_busy);
      issue_wr    = 1'b1;
      issue_lat   = 3'd0;
      freeze      = 1'b0;
      flush       = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_stall", stall, 0);
      check("rst_accept", accept, 0);
`ifdef HAZARD_SCOREBOARD_STATS_EN
      check("rst_stall_cycles", stall_cycles, 0);
      exp_stats = 0;
`endif
      for (int r = 0; r < NREGS; r++) m[r] = 0;
      @(negedge clk);
      issue_valid = 1'b0;
      reset_n     = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n_stall;
      reset_n = 1'b0;
      issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
      issue_wr = 1'b0; issue_lat = '0; freeze = 1'b0; flush = 1'b0;
      for (int r = 0; r < NREGS; r++) m[r] = 0;
      reset_and_check(3);

      // Load then use
      step(1, 0, 0, 5, 1, 1, 0, 0);
      check("lu_issue_accept", last_accept, 1);
      step(1, 5, 0, 0, 0, 0, 0, 0);
      check("lu_stall", last_stall, 1);
      step(1, 5, 0, 0, 0, 0, 0, 0);
      check("lu_accept", last_accept, 1);
      check("lu_busy5", last_busy[5], 0);

      // ALU chain, zero latency
      step(1, 0, 0, 3, 1, 0, 0, 0);
      step(1, 0, 3, 0, 0, 0, 0, 0);
      check("alu_stall", last_stall, 0);
      check("alu_accept", last_accept, 1);
      check("alu_busy3", last_busy[3], 0);

      // WAW: cnt 4,3,2 exceed the new latency 1
      step(1, 0, 0, 7, 1, 4, 0, 0);
      n_stall = 0;
      for (int k = 0; k < 10; k++) begin
         step(1, 0, 0, 7, 1, 1, 0, 0);
         if (last_accept) break;
         n_stall++;
      end
      check("waw_stall_cycles", n_stall, 3);
      check("waw_accepted", last_accept, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("waw_busy7_loaded", last_busy[7], 1);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("waw_busy7_clear", last_busy[7], 0);

      // Flush with concurrent issue
      step(1, 0, 0, 4, 1, 4, 0, 0);
      step(1, 0, 0, 9, 1, 1, 0, 0);
      step(1, 0, 0, 10, 1, 5, 0, 1);
      check("fl_accept", last_accept, 0);
      check("fl_busy4_before", last_busy[4], 1);
      check("fl_busy9_before", last_busy[9], 1);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("fl_busy4", last_busy[4], 0);
      check("fl_busy9", last_busy[9], 0);
      check("fl_busy10", last_busy[10], 0);

      // Freeze holds the table
      step(1, 0, 0, 6, 1, 2, 0, 0);
      for (int k = 0; k < 5; k++) begin
         step(1, 0, 0, 11, 1, 3, 1, 0);
         check("frz_busy6", last_busy[6], 1);
         check("frz_accept", last_accept, 0);
      end
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("frz_rel1_busy6", last_busy[6], 1);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("frz_rel2_busy6", last_busy[6], 1);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("frz_rel3_busy6", last_busy[6], 0);
      check("frz_busy11", last_busy[11], 0);

      // x0 destination and mid-countdown reset
      step(1, 0, 0, 0, 1, 7, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("x0_busy", last_busy, 0);
      step(1, 0, 0, 12, 1, 7, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("pre_rst_busy12", last_busy[12], 1);
      reset_and_check(12);

      // Randomized traffic, registers biased low to provoke hazards
      for (int i = 0; i < 3000; i++) begin
         if (i % 1000 == 999) reset_and_check(int'($urandom_range(1, 7)));
         else step(($urandom_range(0, 9) != 0),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                   int'($urandom_range(0, 7)),
                   ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
